fir8_filter: RTL and testbench

FIR8_FILTER -- requirements
Module: fir8_filter

---
 rtl/fir8_pkg.sv | 12 +
 rtl/fir8_filter_if.sv | 27 ++
 rtl/fir8_round_sat.sv | 46 ++++
 rtl/fir8_filter.sv | 177 +++++++++++++++++
 tb/tb_fir8_filter.sv | 349 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fir8_pkg.sv
// Shared widths and the tap-weight array type for the 8-tap FIR filter.
package fir8_pkg;

    localparam int unsigned NUM_TAPS = 8;
    localparam int unsigned WGT_W    = 10;
    localparam int unsigned PROD_W   = 18;
    localparam int unsigned ACC_W    = 21;

    typedef logic signed [WGT_W-1:0] wgt_t;
    typedef wgt_t wgt_arr_t [NUM_TAPS];

endpackage

// File: rtl/fir8_filter_if.sv
// Pixel stream interface: input side (i_*) and output side (o_*) handshakes.
interface fir8_filter_if #(
    parameter int unsigned PIX_W = 8
);

    logic             i_valid;
    logic             o_ready;
    logic             i_sol;
    logic [PIX_W-1:0] i_pixel;
    logic             o_valid;
    logic             i_ready;
    logic             o_sol;
    logic [PIX_W-1:0] o_pixel;

    // Filter side
    modport slave (
        input  i_valid, i_sol, i_pixel, i_ready,
        output o_ready, o_valid, o_sol, o_pixel
    );

    // Source/sink side
    modport master (
        output i_valid, i_sol, i_pixel, i_ready,
        input  o_ready, o_valid, o_sol, o_pixel
    );

endinterface

// File: rtl/fir8_round_sat.sv
// Rounds, arithmetically shifts and clamps the accumulated sum to a pixel.
module fir8_round_sat
    import fir8_pkg::*;
#(
    parameter int unsigned SHIFT = 8,
    parameter int unsigned PIX_W = 8
) (
    input  logic signed [ACC_W-1:0] sum,
    output logic [PIX_W-1:0]        pix,
    output logic                    clamp
);

    // One extra bit so the rounding add cannot overflow.
    localparam int unsigned EXT_W = ACC_W + 1;
    localparam logic signed [EXT_W-1:0] MAX_V = EXT_W'((64'd1 << PIX_W) - 64'd1);

    logic signed [EXT_W-1:0] ext;
    logic signed [EXT_W-1:0] rnd;
    logic signed [EXT_W-1:0] res;

    assign ext = EXT_W'(sum);

    // Half-LSB rounding term, absent when no shift is applied
    if (SHIFT > 0) begin : g_rnd
        localparam logic signed [EXT_W-1:0] HALF = EXT_W'(1) << (SHIFT - 1);
        assign rnd = ext + HALF;
    end else begin : g_nornd
        assign rnd = ext;
    end

    assign res = rnd >>> SHIFT;

    // Clamp to the unsigned pixel range
    always_comb begin
        pix   = PIX_W'(res);
        clamp = 1'b0;
        if (res < 0) begin
            pix   = '0;
            clamp = 1'b1;
        end else if (res > MAX_V) begin
            pix   = '1;
            clamp = 1'b1;
        end
    end

endmodule

// File: rtl/fir8_filter.sv
// 8-tap line FIR with per-line shadow weights and left-edge replication.
// Three stages: window+products, adder tree, round/saturate. A stalled
// output freezes the whole pipeline.
// Optional macro FIR8_SAT_CNT_EN adds the o_sat_cnt clamp counter.
module fir8_filter
    import fir8_pkg::*;
#(
    parameter int unsigned SHIFT = 8,
    parameter int unsigned PIX_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  wgt_t             i_weight0,
    input  wgt_t             i_weight1,
    input  wgt_t             i_weight2,
    input  wgt_t             i_weight3,
    input  wgt_t             i_weight4,
    input  wgt_t             i_weight5,
    input  wgt_t             i_weight6,
    input  wgt_t             i_weight7,
    fir8_filter_if.slave     s_if
`ifdef FIR8_SAT_CNT_EN
    ,
    output logic [15:0]      o_sat_cnt
`endif
);

    logic stall;
    logic accept;

    wgt_arr_t wgt_in;
    wgt_arr_t wgt_q;
    wgt_arr_t wgt_d;

    logic [PIX_W-1:0]        win_q  [NUM_TAPS];
    logic [PIX_W-1:0]        win_d  [NUM_TAPS];
    logic signed [PROD_W-1:0] prod_d [NUM_TAPS];
    logic signed [PROD_W-1:0] prod_q [NUM_TAPS];

    logic                    s1_valid;
    logic                    s1_sol;
    logic                    s2_valid;
    logic                    s2_sol;
    logic signed [ACC_W-1:0] sum_d;
    logic signed [ACC_W-1:0] s2_sum;

    logic [PIX_W-1:0]        rs_pix;
    logic                    rs_clamp;

    assign wgt_in[0] = i_weight0;
    assign wgt_in[1] = i_weight1;
    assign wgt_in[2] = i_weight2;
    assign wgt_in[3] = i_weight3;
    assign wgt_in[4] = i_weight4;
    assign wgt_in[5] = i_weight5;
    assign wgt_in[6] = i_weight6;
    assign wgt_in[7] = i_weight7;

    assign stall       = s_if.o_valid && !s_if.i_ready;
    assign s_if.o_ready = !stall;
    assign accept      = s_if.i_valid && !stall;

    // Next window and shadow weights; a start-of-line replicates the pixel
    always_comb begin
        win_d = win_q;
        wgt_d = wgt_q;
        if (accept) begin
            if (s_if.i_sol) begin
                for (int unsigned k = 0; k < NUM_TAPS; k++) begin
                    win_d[k] = s_if.i_pixel;
                end
                wgt_d = wgt_in;
            end else begin
                win_d[0] = s_if.i_pixel;
                for (int unsigned k = 1; k < NUM_TAPS; k++) begin
                    win_d[k] = win_q[k-1];
                end
            end
        end
    end

    // Signed products of the zero-extended pixels and the weights
    always_comb begin
        for (int unsigned k = 0; k < NUM_TAPS; k++) begin
            prod_d[k] = $signed({{(PROD_W-PIX_W){1'b0}}, win_d[k]}) * PROD_W'(wgt_d[k]);
        end
    end

    // Full-width adder tree over the registered products
    always_comb begin
        sum_d = '0;
        for (int unsigned k = 0; k < NUM_TAPS; k++) begin
            sum_d = sum_d + ACC_W'(prod_q[k]);
        end
    end

    // S1: window, shadow weights and products
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_sol   <= 1'b0;
            for (int unsigned k = 0; k < NUM_TAPS; k++) begin
                win_q[k]  <= '0;
                wgt_q[k]  <= '0;
                prod_q[k] <= '0;
            end
        end else if (!stall) begin
            s1_valid <= accept;
            s1_sol   <= accept && s_if.i_sol;
            win_q    <= win_d;
            wgt_q    <= wgt_d;
            prod_q   <= prod_d;
        end
    end

    // S2: accumulated sum
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_sol   <= 1'b0;
            s2_sum   <= '0;
        end else if (!stall) begin
            s2_valid <= s1_valid;
            s2_sol   <= s1_sol;
            s2_sum   <= sum_d;
        end
    end

    fir8_round_sat #(
        .SHIFT (SHIFT),
        .PIX_W (PIX_W)
    ) u_round_sat (
        .sum   (s2_sum),
        .pix   (rs_pix),
        .clamp (rs_clamp)
    );

`ifdef FIR8_SAT_CNT_EN
    logic out_clamp;
`else
    logic unused_clamp;
    assign unused_clamp = rs_clamp;
`endif

    // S3: output register, loaded only with valid results
    always_ff @(posedge clk) begin
        if (rst) begin
            s_if.o_valid <= 1'b0;
            s_if.o_sol   <= 1'b0;
            s_if.o_pixel <= '0;
`ifdef FIR8_SAT_CNT_EN
            out_clamp    <= 1'b0;
`endif
        end else if (!stall) begin
            s_if.o_valid <= s2_valid;
            s_if.o_sol   <= s2_sol;
            if (s2_valid) begin
                s_if.o_pixel <= rs_pix;
`ifdef FIR8_SAT_CNT_EN
                out_clamp    <= rs_clamp;
`endif
            end
        end
    end

`ifdef FIR8_SAT_CNT_EN
    // Sticky count of clamped pixels handed downstream
    always_ff @(posedge clk) begin
        if (rst) begin
            o_sat_cnt <= '0;
        end else if (s_if.o_valid && s_if.i_ready && out_clamp && (o_sat_cnt != 16'hFFFF)) begin
            o_sat_cnt <= o_sat_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fir8_filter.sv
// Self-checking bench for fir8_filter: directed scenarios plus random traffic
// checked against a line-window reference model.
module tb_fir8_filter;
    import fir8_pkg::*;

    localparam int unsigned SHIFT = 8;
    localparam int unsigned PIX_W = 8;

    typedef struct {
        int pix;
        bit sol;
        bit clamp;
        int acc_cyc;
        int acc_st;
    } exp_t;

    logic clk;
    logic rst;
    logic signed [WGT_W-1:0] wv [NUM_TAPS];
`ifdef FIR8_SAT_CNT_EN
    logic [15:0] sat_cnt;
`endif

    fir8_filter_if #(.PIX_W(PIX_W)) bus ();

    fir8_filter #(
        .SHIFT (SHIFT),
        .PIX_W (PIX_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .i_weight0 (wv[0]),
        .i_weight1 (wv[1]),
        .i_weight2 (wv[2]),
        .i_weight3 (wv[3]),
        .i_weight4 (wv[4]),
        .i_weight5 (wv[5]),
        .i_weight6 (wv[6]),
        .i_weight7 (wv[7]),
        .s_if      (bus)
`ifdef FIR8_SAT_CNT_EN
        ,
        .o_sat_cnt (sat_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    int   mwin [NUM_TAPS];
    int   mwgt [NUM_TAPS];
    exp_t q [$];
    int   got [$];
    int   cyc = 0;
    int   stall_total = 0;
    int   msat = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: dot product, round, arithmetic shift, clamp
    function automatic int ref_pix(input int win [NUM_TAPS], input int w [NUM_TAPS], output bit clamp);
        longint sum;
        longint half;
        longint r;
        sum = 0;
        for (int k = 0; k < NUM_TAPS; k++) sum += longint'(win[k]) * longint'(w[k]);
        half = (SHIFT > 0) ? (longint'(1) << (SHIFT - 1)) : 0;
        r = (sum + half) >>> SHIFT;
        clamp = 1'b0;
        if (r < 0) begin
            r = 0;
            clamp = 1'b1;
        end else if (r > longint'((1 << PIX_W) - 1)) begin
            r = longint'((1 << PIX_W) - 1);
            clamp = 1'b1;
        end
        return int'(r);
    endfunction

    // Per-cycle monitor: compare outputs, then advance the model
    always @(negedge clk) begin
        exp_t e;
        bit   cl;
        bit   acc;
        cyc++;
`ifdef FIR8_SAT_CNT_EN
        chk("sat_cnt", int'(sat_cnt), msat);
`endif
        chk("o_ready", int'(bus.o_ready), int'(!(bus.o_valid && !bus.i_ready)));
        if (bus.o_valid === 1'b1) begin
            chk("out_expected", int'(q.size() > 0), 1);
            if (q.size() > 0) begin
                chk("o_pixel", int'(bus.o_pixel), q[0].pix);
                chk("o_sol", int'(bus.o_sol), int'(q[0].sol));
                if (bus.i_ready) begin
                    e = q.pop_front();
                    got.push_back(int'(bus.o_pixel));
                    chk("latency", cyc - e.acc_cyc - (stall_total - e.acc_st), 3);
                    if (e.clamp && msat < 65535) msat++;
                end
            end
        end
        acc = bus.i_valid && bus.o_ready;
        if (rst) begin
            q.delete();
            for (int k = 0; k < NUM_TAPS; k++) begin
                mwin[k] = 0;
                mwgt[k] = 0;
            end
            msat = 0;
        end else if (acc) begin
            if (bus.i_sol) begin
                for (int k = 0; k < NUM_TAPS; k++) begin
                    mwin[k] = int'(bus.i_pixel);
                    mwgt[k] = int'(wv[k]);
                end
            end else begin
                for (int k = NUM_TAPS - 1; k > 0; k--) mwin[k] = mwin[k-1];
                mwin[0] = int'(bus.i_pixel);
            end
            e.pix     = ref_pix(mwin, mwgt, cl);
            e.clamp   = cl;
            e.sol     = bus.i_sol;
            e.acc_cyc = cyc;
            e.acc_st  = stall_total;
            q.push_back(e);
        end
        if (bus.o_valid === 1'b1 && !bus.i_ready) stall_total++;
    end

    // All tasks start and end just after a rising edge
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input int pix, input bit sol);
        bit acc;
        int n;
        n = 0;
        bus.i_valid = 1'b1;
        bus.i_pixel = PIX_W'(pix);
        bus.i_sol   = sol;
        do begin
            @(negedge clk);
            acc = bus.o_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 50);
        if (!acc) chk("send_timeout", 0, 1);
        bus.i_valid = 1'b0;
        bus.i_sol   = 1'b0;
    endtask

    task automatic set_w(input int w0, input int rest);
        wv[0] = WGT_W'(w0);
        for (int k = 1; k < NUM_TAPS; k++) wv[k] = WGT_W'(rest);
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
    endtask

    task automatic check_got(input string name, input int exp [$]);
        chk({name, "_count"}, got.size(), exp.size());
        for (int i = 0; i < exp.size() && i < got.size(); i++) chk(name, got[i], exp[i]);
        got.delete();
    endtask

    initial begin
        int  ew [$];
        int  tw [NUM_TAPS];
        int  tx [NUM_TAPS];
        bit  tc;
        int  tmp;

        rst         = 1'b1;
        bus.i_valid = 1'b0;
        bus.i_sol   = 1'b0;
        bus.i_pixel = '0;
        bus.i_ready = 1'b1;
        set_w(0, 0);

        // Hand-computed pins on the reference model
        for (int k = 0; k < NUM_TAPS; k++) begin tw[k] = 0; tx[k] = 0; end
        tw[0] = 256; tx[0] = 10;
        chk("model_identity", ref_pix(tx, tw, tc), 10);
        for (int k = 0; k < NUM_TAPS; k++) tw[k] = 32;
        tx[0] = 200;
        chk("model_box_step", ref_pix(tx, tw, tc), 25);
        for (int k = 0; k < NUM_TAPS; k++) begin tw[k] = 0; tx[k] = 255; end
        tw[0] = 511;
        chk("model_sat_hi", ref_pix(tx, tw, tc), 255);
        chk("model_sat_hi_clamp", int'(tc), 1);
        tw[0] = -512;
        chk("model_sat_lo", ref_pix(tx, tw, tc), 0);

        tick(2);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_o_valid", int'(bus.o_valid), 0);
        chk("rst_o_pixel", int'(bus.o_pixel), 0);
        chk("rst_o_sol", int'(bus.o_sol), 0);
        chk("rst_o_ready", int'(bus.o_ready), 1);
        @(posedge clk);
        #1;

        // Identity with explicit 3-cycle latency
        set_w(256, 0);
        got.delete();
        send(10, 1'b1);
        @(negedge clk); chk("id_lat1_valid", int'(bus.o_valid), 0);
        @(negedge clk); chk("id_lat2_valid", int'(bus.o_valid), 0);
        @(negedge clk);
        chk("id_lat3_valid", int'(bus.o_valid), 1);
        chk("id_lat3_pixel", int'(bus.o_pixel), 10);
        chk("id_lat3_sol", int'(bus.o_sol), 1);
        @(posedge clk);
        #1;
        send(20, 1'b0);
        send(30, 1'b0);
        tick(6);
        ew = '{10, 20, 30};
        check_got("identity", ew);

        // Box average: constant line, then a 0 -> 200 step
        set_w(32, 32);
        send(100, 1'b1);
        repeat (7) send(100, 1'b0);
        tick(6);
        ew = '{100, 100, 100, 100, 100, 100, 100, 100};
        check_got("box_const", ew);
        send(0, 1'b1);
        repeat (8) send(200, 1'b0);
        tick(6);
        ew = '{0, 25, 50, 75, 100, 125, 150, 175, 200};
        check_got("box_step", ew);

        // Mid-line weight change waits for the next start-of-line
        set_w(256, 0);
        send(200, 1'b1);
        send(200, 1'b0);
        set_w(128, 0);
        send(200, 1'b0);
        send(200, 1'b1);
        tick(6);
        ew = '{200, 200, 200, 100};
        check_got("shadow", ew);

        // Saturation in both directions
        pulse_rst();
        set_w(511, 0);
        send(255, 1'b1);
        set_w(-512, 0);
        send(255, 1'b1);
        tick(6);
        ew = '{255, 0};
        check_got("saturate", ew);
`ifdef FIR8_SAT_CNT_EN
        @(negedge clk);
        chk("sat_cnt_two", int'(sat_cnt), 2);
        @(posedge clk);
        #1;
`endif

        // Backpressure: five stalled cycles mid-stream
        set_w(256, 0);
        send(1, 1'b1);
        for (int p = 2; p <= 5; p++) send(p, 1'b0);
        fork
            begin
                for (int p = 6; p <= 10; p++) send(p, 1'b0);
            end
            begin
                bus.i_ready = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    chk("bp_o_ready", int'(bus.o_ready), 0);
                    chk("bp_o_valid", int'(bus.o_valid), 1);
                    chk("bp_o_pixel", int'(bus.o_pixel), 3);
                end
                @(posedge clk);
                #1;
                bus.i_ready = 1'b1;
            end
        join
        tick(8);
        ew = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10};
        check_got("backpressure", ew);

        // Reset with three pixels in flight
        send(50, 1'b1);
        send(60, 1'b0);
        send(70, 1'b0);
        pulse_rst();
        @(negedge clk);
        chk("mid_rst_o_valid", int'(bus.o_valid), 0);
        chk("mid_rst_o_pixel", int'(bus.o_pixel), 0);
        chk("mid_rst_o_ready", int'(bus.o_ready), 1);
        @(posedge clk);
        #1;
        got.delete();
        tick(5);
        send(80, 1'b0);
        send(90, 1'b1);
        tick(6);
        ew = '{0, 90};
        check_got("after_rst", ew);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            rst         = ($urandom_range(0, 299) == 0);
            bus.i_valid = ($urandom_range(0, 9) < 7);
            bus.i_sol   = ($urandom_range(0, 15) == 0);
            bus.i_pixel = PIX_W'($urandom_range(0, 255));
            bus.i_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 19) == 0) begin
                if ($urandom_range(0, 3) == 0) tmp = int'($urandom_range(0, 1023)) - 512;
                else                           tmp = int'($urandom_range(0, 160)) - 64;
                wv[$urandom_range(0, NUM_TAPS - 1)] = WGT_W'(tmp);
            end
            tick(1);
        end
        rst         = 1'b0;
        bus.i_valid = 1'b0;
        bus.i_sol   = 1'b0;
        bus.i_ready = 1'b1;
        tick(10);
        chk("drained", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
